// File: rtl/tt_um_couchand_cora16_pkg.sv
// Shared definitions for the CORA16 accumulator machine: opcodes, SPI RAM
// commands, controller state encodings and a small immediate helper.
package tt_um_couchand_cora16_pkg;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_TRAP = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_PUSH = 4'h3;
    localparam logic [3:0] OP_POP  = 4'h4;
    localparam logic [3:0] OP_DROP = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_LDS  = 4'hE;
    localparam logic [3:0] OP_RSVD = 4'hF;

    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;

    // command + 24-bit address + one 16-bit data word
    localparam int SPI_FRAME_BITS = 48;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_HALTED,
        ST_TRAPPED
    } core_state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_GAP
    } spi_state_t;

    // Widen a 12-bit immediate to a full machine word, keeping its sign.
    function automatic logic [15:0] sext12(input logic [11:0] k);
        return {{4{k[11]}}, k};
    endfunction

endpackage

// File: rtl/tt_um_couchand_cora16_if.sv
// Word-transfer request channel between the core sequencer and the SPI
// master, bundled with the serial RAM pins that the master drives.
interface tt_um_couchand_cora16_if;

    logic        start;
    logic        write;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;

    logic        spi_clk;
    logic        spi_select;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output start, write, addr, wdata,
        input  rdata, done
    );

    modport slave (
        input  start, write, addr, wdata,
        output rdata, done,
        output spi_clk, spi_select, spi_mosi,
        input  spi_miso
    );

endinterface

// File: rtl/tt_um_couchand_cora16_spi_master.sv
// Single-word SPI RAM transfer engine: mode 0, MSB first, spi_clk = clk/2.
// A held start launches one 48-bit frame; done pulses for one clock when the
// frame completes, and select then stays low for a short recovery gap.
module spi_master
    import tt_um_couchand_cora16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    tt_um_couchand_cora16_if.slave   bus
);

    spi_state_t  state;
    logic [47:0] tx;
    logic [5:0]  bit_cnt;
    logic [15:0] rx;
    logic        gap_cnt;
    logic [47:0] frame;

    assign frame    = {(bus.write ? SPI_CMD_WRITE : SPI_CMD_READ), bus.addr, bus.wdata};
    assign bus.rdata = rx;

    // Frame sequencer: toggles spi_clk each clock, shifts MOSI on the falling
    // half and captures MISO as spi_clk rises; reset drops select at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SPI_IDLE;
            tx             <= '0;
            bit_cnt        <= '0;
            rx             <= '0;
            gap_cnt        <= 1'b0;
            bus.spi_clk    <= 1'b0;
            bus.spi_select <= 1'b0;
            bus.spi_mosi   <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (bus.start) begin
                        bus.spi_select <= 1'b1;
                        bus.spi_mosi   <= frame[47];
                        tx             <= {frame[46:0], 1'b0};
                        bit_cnt        <= '0;
                        state          <= SPI_SHIFT;
                    end
                end
                SPI_SHIFT: begin
                    if (!bus.spi_clk) begin
                        bus.spi_clk <= 1'b1;
                        rx          <= {rx[14:0], bus.spi_miso};
                    end else begin
                        bus.spi_clk <= 1'b0;
                        if (bit_cnt == 6'(SPI_FRAME_BITS - 1)) begin
                            bus.spi_select <= 1'b0;
                            bus.spi_mosi   <= 1'b0;
                            bus.done       <= 1'b1;
                            gap_cnt        <= 1'b0;
                            state          <= SPI_GAP;
                        end else begin
                            bus.spi_mosi <= tx[47];
                            tx           <= {tx[46:0], 1'b0};
                            bit_cnt      <= bit_cnt + 6'd1;
                        end
                    end
                end
                SPI_GAP: begin
                    if (gap_cnt) begin
                        state <= SPI_IDLE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_couchand_cora16.sv
// CORA16: a 16-bit accumulator/stack machine whose program, data and stack
// all live in an external SPI RAM. The core sequences fetch, execute and
// optional memory transfers through the spi_master engine.
module tt_um_couchand_cora16
    import tt_um_couchand_cora16_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    tt_um_couchand_cora16_if bus ();

    core_state_t state;
    logic [15:0] acc;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] ir;
    logic        halt;
    logic        trap;

    logic [3:0]  opcode;
    logic [11:0] k;
    logic [15:0] k_sext;
    logic [15:0] k_zext;
    logic [15:0] sp_dec;
    logic [15:0] sp_inc;
    logic [15:0] sp_off;
    logic        unused;

    assign opcode = ir[15:12];
    assign k      = ir[11:0];
    assign k_sext = sext12(k);
    assign k_zext = {4'h0, k};
    assign sp_dec = sp - 16'd2;
    assign sp_inc = sp + 16'd2;
    assign sp_off = sp + k_sext;

    assign bus.spi_miso = uio_in[3];

    assign uo_out  = ui_in[0] ? acc[15:8] : acc[7:0];
    assign uio_out = {trap, halt, bus.spi_select, 2'b00, bus.spi_clk, bus.spi_select, bus.spi_mosi};
    assign uio_oe  = 8'b1110_0111;
    assign unused  = &{1'b0, ena, ui_in[7:1], uio_in[7:4], uio_in[2:0]};

    spi_master u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Core sequencer: fetch a word at PC, decode it, launch at most one
    // memory transfer and retire its result before the next fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            acc       <= '0;
            pc        <= '0;
            sp        <= '0;
            ir        <= '0;
            halt      <= 1'b0;
            trap      <= 1'b0;
            bus.start <= 1'b0;
            bus.write <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    bus.start <= 1'b1;
                    bus.write <= 1'b0;
                    bus.addr  <= {8'h00, pc};
                    state     <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    if (bus.done) begin
                        bus.start <= 1'b0;
                        ir        <= bus.rdata;
                        pc        <= pc + 16'd2;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (opcode)
                        OP_HALT: begin
                            halt  <= 1'b1;
                            state <= ST_HALTED;
                        end
                        OP_LDI: acc <= k_sext;
                        OP_PUSH: begin
                            sp        <= sp_dec;
                            bus.start <= 1'b1;
                            bus.write <= 1'b1;
                            bus.addr  <= {8'h00, sp_dec};
                            bus.wdata <= acc;
                            state     <= ST_MEM_WAIT;
                        end
                        OP_POP, OP_ADD, OP_SUB, OP_RET: begin
                            bus.start <= 1'b1;
                            bus.write <= 1'b0;
                            bus.addr  <= {8'h00, sp};
                            state     <= ST_MEM_WAIT;
                        end
                        OP_DROP: sp <= sp_inc;
                        OP_LD: begin
                            bus.start <= 1'b1;
                            bus.write <= 1'b0;
                            bus.addr  <= {8'h00, k_zext};
                            state     <= ST_MEM_WAIT;
                        end
                        OP_ST: begin
                            bus.start <= 1'b1;
                            bus.write <= 1'b1;
                            bus.addr  <= {8'h00, k_zext};
                            bus.wdata <= acc;
                            state     <= ST_MEM_WAIT;
                        end
                        OP_JMP: pc <= k_zext;
                        OP_JZ: begin
                            if (acc == 16'h0000) begin
                                pc <= k_zext;
                            end
                        end
                        OP_CALL: begin
                            sp        <= sp_dec;
                            pc        <= k_zext;
                            bus.start <= 1'b1;
                            bus.write <= 1'b1;
                            bus.addr  <= {8'h00, sp_dec};
                            bus.wdata <= pc;
                            state     <= ST_MEM_WAIT;
                        end
                        OP_LDS: begin
                            bus.start <= 1'b1;
                            bus.write <= 1'b0;
                            bus.addr  <= {8'h00, sp_off};
                            state     <= ST_MEM_WAIT;
                        end
                        default: begin
                            trap  <= 1'b1;
                            state <= ST_TRAPPED;
                        end
                    endcase
                end
                ST_MEM_WAIT: begin
                    if (bus.done) begin
                        bus.start <= 1'b0;
                        state     <= ST_FETCH;
                        case (opcode)
                            OP_POP: begin
                                acc <= bus.rdata;
                                sp  <= sp_inc;
                            end
                            OP_ADD: begin
                                acc <= acc + bus.rdata;
                                sp  <= sp_inc;
                            end
                            OP_SUB: begin
                                acc <= bus.rdata - acc;
                                sp  <= sp_inc;
                            end
                            OP_RET: begin
                                pc <= bus.rdata;
                                sp <= sp_inc;
                            end
                            OP_LD, OP_LDS: acc <= bus.rdata;
                            default: ;
                        endcase
                    end
                end
                ST_HALTED:  state <= ST_HALTED;
                ST_TRAPPED: state <= ST_TRAPPED;
                default:    state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_couchand_cora16.sv
// Directed bench for CORA16: a behavioural SPI RAM answers the core's frames,
// small hand-assembled programs run to HALT/TRAP and results are compared
// against hand-computed values.
module tb_tt_um_couchand_cora16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       miso = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    tt_um_couchand_cora16_if sniff ();

    assign sniff.spi_mosi   = uio_out[0];
    assign sniff.spi_select = uio_out[1];
    assign sniff.spi_clk    = uio_out[2];
    assign sniff.spi_miso   = miso;
    assign uio_in           = {4'b0000, miso, 3'b000};

    tt_um_couchand_cora16 dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    // SPI RAM model state
    logic [7:0]  mem [0:65535];
    logic [47:0] sh = '0;
    int          bit_cnt = 0;
    logic [15:0] rd_word = '0;
    logic [15:0] a16;
    int          read_count = 0;
    int          write_count = 0;
    int          fffe_reads = 0;
    logic [23:0] read_log [$];

    // Serial RAM: select rising restarts the frame, spi_clk rising shifts in
    // MOSI, the command/address decode after 32 bits, writes land after 48.
    always @(posedge sniff.spi_clk or posedge sniff.spi_select) begin
        if (!sniff.spi_clk) begin
            bit_cnt = 0;
        end else if (sniff.spi_select) begin
            sh = {sh[46:0], sniff.spi_mosi};
            bit_cnt = bit_cnt + 1;
            if (bit_cnt == 32 && sh[31:24] == 8'h03) begin
                a16 = sh[15:0];
                read_count = read_count + 1;
                read_log.push_back(sh[23:0]);
                if (sh[23:0] == 24'h00FFFE) fffe_reads = fffe_reads + 1;
                rd_word = {mem[a16], mem[a16 + 16'd1]};
            end
            if (bit_cnt == 48 && sh[47:40] == 8'h02) begin
                a16 = sh[31:16];
                mem[a16] = sh[15:8];
                mem[a16 + 16'd1] = sh[7:0];
                write_count = write_count + 1;
            end
        end
    end

    // Read data goes out MSB first, changing on each falling spi_clk.
    always @(negedge sniff.spi_clk) begin
        if (sniff.spi_select && bit_cnt >= 32 && bit_cnt < 48) begin
            miso <= rd_word[47 - bit_cnt];
        end
    end

    int ptr = 0;

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task begin_program();
        rst_n = 1'b0;
        ui_in = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        ptr = 0;
    endtask

    task emit(input logic [15:0] w);
        mem[ptr]     = w[15:8];
        mem[ptr + 1] = w[7:0];
        ptr = ptr + 2;
    endtask

    task applyStimulus(input string tag, input int max_cycles);
        int c;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (!uio_out[1] && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput({tag, " first fetch latency"}, (c <= 4), 1);
        c = 0;
        while (!(uio_out[6] || uio_out[7]) && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput({tag, " stopped"}, (uio_out[6] || uio_out[7]), 1);
    endtask

    task check_acc(input string tag, input logic [15:0] exp);
        ui_in = 8'h00;
        #1;
        checkOutput({tag, " A lo"}, uo_out, exp[7:0]);
        ui_in = 8'h01;
        #1;
        checkOutput({tag, " A hi"}, uo_out, exp[15:8]);
        ui_in = 8'h00;
    endtask

    int rc0, wc0, fc0;

    initial begin
        $display("[TB] CORA16 directed test start");

        // reset state
        begin_program();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset uio_out", uio_out, 8'h00);
        checkOutput("reset uio_oe", uio_oe, 8'hE7);
        check_acc("reset", 16'h0000);

        // HALT at word 0: one fetch only
        begin_program();
        emit(16'h0000);
        rc0 = read_count; wc0 = write_count;
        applyStimulus("halt0", 2000);
        checkOutput("halt0 halt", uio_out[6], 1);
        checkOutput("halt0 trap", uio_out[7], 0);
        checkOutput("halt0 busy", uio_out[5], 0);
        checkOutput("halt0 reads", read_count - rc0, 1);
        checkOutput("halt0 writes", write_count - wc0, 0);

        // TRAP and reserved opcode
        begin_program();
        emit(16'h1000);
        applyStimulus("trap1", 2000);
        checkOutput("trap1 trap", uio_out[7], 1);
        checkOutput("trap1 halt", uio_out[6], 0);
        begin_program();
        emit(16'hF000);
        applyStimulus("trapF", 2000);
        checkOutput("trapF trap", uio_out[7], 1);
        checkOutput("trapF halt", uio_out[6], 0);

        // LDI 5; PUSH; HALT
        begin_program();
        emit(16'h2005); emit(16'h3000); emit(16'h0000);
        applyStimulus("push", 4000);
        checkOutput("push mem FFFE", mem[16'hFFFE], 8'h00);
        checkOutput("push mem FFFF", mem[16'hFFFF], 8'h05);
        checkOutput("push halt", uio_out[6], 1);
        check_acc("push", 16'h0005);

        // LDI 7; PUSH; LDI 0; POP; HALT
        begin_program();
        emit(16'h2007); emit(16'h3000); emit(16'h2000); emit(16'h4000); emit(16'h0000);
        applyStimulus("pop", 6000);
        check_acc("pop", 16'h0007);

        // LDI 7; PUSH; DROP; HALT
        begin_program();
        emit(16'h2007); emit(16'h3000); emit(16'h5000); emit(16'h0000);
        fc0 = fffe_reads;
        applyStimulus("drop", 6000);
        check_acc("drop", 16'h0007);
        checkOutput("drop no stack read", fffe_reads - fc0, 0);

        // sign extension and wrap: LDI -1; PUSH; LDI 1; ADD; HALT
        begin_program();
        emit(16'h2FFF); emit(16'h3000); emit(16'h2001); emit(16'h6000); emit(16'h0000);
        applyStimulus("wrap", 6000);
        check_acc("wrap", 16'h0000);
        checkOutput("wrap pushed hi", mem[16'hFFFE], 8'hFF);

        // iterative Fibonacci(10) with variables at 0x100/0x102/0x104
        begin_program();
        emit(16'h2000); emit(16'h9100); emit(16'h2001); emit(16'h9102);
        emit(16'h200A); emit(16'h9104);
        emit(16'h8104); emit(16'hB028); emit(16'h8100); emit(16'h3000);
        emit(16'h8102); emit(16'h9100); emit(16'h6000); emit(16'h9102);
        emit(16'h8104); emit(16'h3000); emit(16'h2001); emit(16'h7000);
        emit(16'h9104); emit(16'hA00C);
        emit(16'h8100); emit(16'h0000);
        applyStimulus("fib_iter", 40000);
        checkOutput("fib_iter halt", uio_out[6], 1);
        check_acc("fib_iter", 16'h0037);

        // recursive Fibonacci(10) with stack frames: F(n,a,b) = n ? F(n-1,b,a+b) : a
        begin_program();
        emit(16'h200A); emit(16'h3000); emit(16'h2000); emit(16'h3000);
        emit(16'h2001); emit(16'h3000); emit(16'hC010); emit(16'h0000);
        emit(16'hE006); emit(16'hB036); emit(16'hE006); emit(16'h3000);
        emit(16'h2001); emit(16'h7000); emit(16'h3000); emit(16'hE004);
        emit(16'h3000); emit(16'hE008); emit(16'h3000); emit(16'hE008);
        emit(16'h6000); emit(16'h3000); emit(16'hC010); emit(16'h5000);
        emit(16'h5000); emit(16'h5000); emit(16'hD000);
        emit(16'hE004); emit(16'hD000);
        applyStimulus("fib_rec", 50000);
        checkOutput("fib_rec halt", uio_out[6], 1);
        check_acc("fib_rec", 16'h0037);

        // reset in the middle of the first fetch frame
        begin_program();
        emit(16'h2005); emit(16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("midreset select before", uio_out[1], 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset select", uio_out[1], 0);
        checkOutput("midreset busy", uio_out[5], 0);
        checkOutput("midreset sclk", uio_out[2], 0);
        rc0 = read_count;
        applyStimulus("midreset", 4000);
        checkOutput("midreset refetch addr", (read_log.size() > rc0) ? read_log[rc0] : 24'hFFFFFF, 24'h000000);
        check_acc("midreset", 16'h0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
